debounce_scan_ctrl: RTL and testbench

- Multi-channel debounce controller that shares one tick prescaler across NCH raw switch inputs.
- Produces per-channel debounced levels.
- Serialises every debounced edge into a single event stream through a round-robin arbiter with a valid/ready handshake.
- Sits between board switch pins and the front-panel/command logic.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_chan.sv | 61 ++++++
 rtl/debounce_scan_ctrl.sv | 107 ++++++++++
 tb/tb_debounce_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debounce controller.
package debounce_pkg;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

  localparam int DEF_WAIT = 3;
  localparam int DEF_N    = 19;
  localparam int CNT_W    = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: 2-FF synchroniser, tick-based wait counter and debounced level.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int WAIT = DEF_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw_i,
  output logic db_o,
  output logic edge_o,
  output logic edge_dir_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT - 1);

  logic             sync_p0, sync_p1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             db_q, db_nxt;
  logic             flip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      db_q    <= 1'b0;
    end else begin
      sync_p0 <= sw_i;
      sync_p1 <= sync_p0;
      cnt     <= cnt_nxt;
      db_q    <= db_nxt;
    end
  end

  // A return to the current level cancels any wait in progress, tick or not.
  always_comb begin
    flip    = 1'b0;
    cnt_nxt = cnt;
    db_nxt  = db_q;
    if (sync_p1 == db_q) begin
      cnt_nxt = '0;
    end else if (tick) begin
      if (cnt == LAST) begin
        flip    = 1'b1;
        cnt_nxt = '0;
        db_nxt  = ~db_q;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    db_o       = db_q;
    edge_o     = flip;
    edge_dir_o = db_q ? EDGE_FALL : EDGE_RISE;
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Shared-prescaler debouncer for NCH switches; debounced edges are serialised
// through a round-robin arbiter into one valid/ready event stream.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int N    = DEF_N,
  parameter int WAIT = DEF_WAIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NCH-1:0]         sw,
  output logic [NCH-1:0]         db,
  output logic                   tick,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [clog2(NCH)-1:0]  evt_ch,
  output logic                   evt_edge,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int CW = clog2(NCH);

  logic [N-1:0]   presc;
  logic [NCH-1:0] edge_v, dir_v;
  logic [NCH-1:0] pend, pend_nxt, pedge, pedge_nxt;
  logic [CW-1:0]  last_grant, sel;
  logic           found, load, grant, ovf_set;

  always_ff @(posedge clk) begin
    if (!rst_n) presc <= '0;
    else if (en) presc <= presc + N'(1);
  end

  assign tick = en & (&presc);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(.WAIT(WAIT)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .sw_i      (sw[i]),
      .db_o      (db[i]),
      .edge_o    (edge_v[i]),
      .edge_dir_o(dir_v[i])
    );
  end

  // Round-robin search starts just after the last channel granted.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!found && pend[(int'(last_grant) + k) % NCH]) begin
        found = 1'b1;
        sel   = CW'((int'(last_grant) + k) % NCH);
      end
    end
  end

  assign load  = ~evt_valid | evt_ready;
  assign grant = load & found;

  // An edge landing on a still-pending channel merges and flags overflow,
  // unless that channel's old edge is leaving this very cycle.
  always_comb begin
    pend_nxt  = pend;
    pedge_nxt = pedge;
    ovf_set   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant && sel == CW'(i)) pend_nxt[i] = 1'b0;
      if (edge_v[i]) begin
        if (pend[i] && !(grant && sel == CW'(i))) ovf_set = 1'b1;
        pend_nxt[i]  = 1'b1;
        pedge_nxt[i] = dir_v[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend       <= '0;
      pedge      <= '0;
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      evt_edge   <= 1'b0;
      ovf        <= 1'b0;
      last_grant <= CW'(NCH - 1);
    end else begin
      pend  <= pend_nxt;
      pedge <= pedge_nxt;
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_ch     <= sel;
          evt_edge   <= pedge[sel];
          last_grant <= sel;
        end
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed and randomised bench for debounce_scan_ctrl with a cycle-level reference model.
module tb_debounce_scan_ctrl;

  localparam int NCH    = 4;
  localparam int N      = 4;
  localparam int WAIT   = 3;
  localparam int PERIOD = 1 << N;

  logic           clk = 1'b0;
  logic           rst_n, en, evt_ready, ovf_clr;
  logic [NCH-1:0] sw;
  logic [NCH-1:0] db;
  logic           tick, evt_valid, evt_edge, ovf;
  logic [1:0]     evt_ch;

  int tests = 0;
  int fails = 0;

  debounce_scan_ctrl #(.NCH(NCH), .N(N), .WAIT(WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sw(sw), .db(db), .tick(tick),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_edge(evt_edge), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model state: plain integers and arrays, updated once per clock.
  int m_presc, m_ch, m_lg;
  bit m_s1[NCH], m_s2[NCH], m_db[NCH], m_pend[NCH], m_pedge[NCH];
  int m_ticks[NCH];
  bit m_valid, m_edge, m_ovf;

  logic [2:0] evq[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit tk, ovf_set;
    int g;
    if (!rst_n) begin
      m_presc = 0; m_valid = 0; m_ch = 0; m_edge = 0; m_ovf = 0; m_lg = NCH - 1;
      for (int i = 0; i < NCH; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_pend[i] = 0; m_pedge[i] = 0; m_ticks[i] = 0;
      end
      return;
    end
    tk = en && (m_presc == PERIOD - 1);
    ovf_set = 0;
    g = -1;
    if (!m_valid || evt_ready) begin
      for (int k = 1; k <= NCH; k++)
        if (g < 0 && m_pend[(m_lg + k) % NCH]) g = (m_lg + k) % NCH;
      if (g >= 0) begin
        m_valid = 1; m_ch = g; m_edge = m_pedge[g]; m_pend[g] = 0; m_lg = g;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (m_s2[i] == m_db[i]) m_ticks[i] = 0;
      else if (tk) begin
        m_ticks[i]++;
        if (m_ticks[i] == WAIT) begin
          m_db[i] = !m_db[i];
          m_ticks[i] = 0;
          if (m_pend[i]) ovf_set = 1;
          m_pend[i] = 1;
          m_pedge[i] = m_db[i];
        end
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = sw[i];
    end
    if (en) m_presc = (m_presc + 1) % PERIOD;
    if (ovf_set) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
  endtask

  task automatic cyc();
    logic [9:0] exp_v;
    if (rst_n && evt_valid && evt_ready) evq.push_back({evt_ch, evt_edge});
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NCH; i++) exp_v[6+i] = m_db[i];
    exp_v[5]   = en && (m_presc == PERIOD - 1);
    exp_v[4]   = m_valid;
    exp_v[3:2] = 2'(m_ch);
    exp_v[1]   = m_edge;
    exp_v[0]   = m_ovf;
    check("cycle", {22'd0, db, tick, evt_valid, evt_ch, evt_edge, ovf}, {22'd0, exp_v});
  endtask

  task automatic wait_db(int ch, logic val, int maxc, output int n);
    n = 0;
    while (db[ch] !== val && n < maxc) begin
      cyc();
      n++;
    end
    check("wait_db", {31'd0, db[ch]}, {31'd0, val});
  endtask

  task automatic wait_valid(int maxc);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < maxc) begin
      cyc();
      n++;
    end
    check("wait_valid", {31'd0, evt_valid}, 32'd1);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int n;
    bit ok;
    logic [NCH-1:0] db_save;

    // Reset with all switches high
    rst_n = 0; en = 1; evt_ready = 1; ovf_clr = 0; sw = 4'hF;
    run(3);
    check("rst_db", {28'd0, db}, 32'd0);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1;
    evq.delete();
    n = 0;
    while (db !== 4'hF && n < 60) begin cyc(); n++; end
    check("rst_db_all", {28'd0, db}, 32'hF);
    check("rst_db_time", {31'd0, n <= 50}, 32'd1);
    run(6);
    check("rst_evcount", evq.size(), 32'd4);
    for (int i = 0; i < NCH; i++)
      if (evq.size() > i) check("rst_ev_order", {29'd0, evq[i]}, {29'd0, 2'(i), 1'b1});

    // Bounce on ch1 from a clean zero state
    rst_n = 0; sw = 4'h0;
    run(3);
    rst_n = 1;
    run(2);
    evq.delete();
    ok = 1;
    for (int seg = 0; seg < 8; seg++) begin
      sw[1] = (seg % 2 == 0);
      for (int c = 0; c < 5; c++) begin
        cyc();
        if (db[1] !== 1'b0) ok = 0;
      end
    end
    check("bounce_stays_low", {31'd0, ok}, 32'd1);
    sw[1] = 1;
    wait_db(1, 1'b1, 60, n);
    check("bounce_delay", {31'd0, (n >= 33 && n <= 50)}, 32'd1);
    run(4);
    check("bounce_evcount", evq.size(), 32'd1);
    if (evq.size() > 0) check("bounce_ev", {29'd0, evq[0]}, {29'd0, 3'b011});

    // Backpressure on ch2
    evt_ready = 0;
    sw[2] = 1;
    wait_valid(60);
    check("bp_ch", {30'd0, evt_ch}, 32'd2);
    check("bp_edge", {31'd0, evt_edge}, 32'd1);
    ok = 1;
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (!(evt_valid === 1'b1 && evt_ch === 2'd2 && evt_edge === 1'b1)) ok = 0;
    end
    check("bp_hold", {31'd0, ok}, 32'd1);
    evt_ready = 1;
    cyc();
    evt_ready = 0;
    check("bp_drop", {31'd0, evt_valid}, 32'd0);

    // Round robin: grant ch0 first, then ch3 and ch0 edge together
    evt_ready = 1;
    sw[0] = 1;
    wait_db(0, 1'b1, 60, n);
    run(4);
    evq.delete();
    sw[0] = 0; sw[3] = 1;
    wait_db(3, 1'b1, 60, n);
    run(4);
    check("rr_evcount", evq.size(), 32'd2);
    if (evq.size() > 1) begin
      check("rr_first", {29'd0, evq[0]}, {29'd0, 3'b111});
      check("rr_second", {29'd0, evq[1]}, {29'd0, 3'b000});
    end

    // Overflow: ch1 event parked, ch0 rises and falls behind it
    evt_ready = 0;
    sw[1] = 0;
    wait_valid(60);
    check("ovf_park_ch", {30'd0, evt_ch}, 32'd1);
    sw[0] = 1;
    wait_db(0, 1'b1, 60, n);
    sw[0] = 0;
    wait_db(0, 1'b0, 60, n);
    cyc();
    check("ovf_set", {31'd0, ovf}, 32'd1);
    evq.delete();
    evt_ready = 1;
    run(2);
    evt_ready = 0;
    check("ovf_popcount", evq.size(), 32'd2);
    if (evq.size() > 1) check("ovf_pop_ch0", {29'd0, evq[1]}, {29'd0, 3'b000});
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    ovf_clr = 1;
    cyc();
    ovf_clr = 0;
    check("ovf_clr", {31'd0, ovf}, 32'd0);

    // Enable freeze
    evt_ready = 1;
    en = 0;
    db_save = db;
    sw[3] = 0;
    ok = 1;
    for (int c = 0; c < 200; c++) begin
      cyc();
      if (tick !== 1'b0 || db !== db_save) ok = 0;
    end
    check("en_freeze", {31'd0, ok}, 32'd1);
    en = 1;
    wait_db(3, 1'b0, 60, n);
    check("en_resume_delay", {31'd0, (n >= 33 && n <= 48)}, 32'd1);
    run(4);

    // Randomised traffic including occasional resets
    for (int c = 0; c < 3000; c++) begin
      evt_ready = 1'($urandom % 2);
      ovf_clr   = ($urandom % 50) == 0;
      en        = ($urandom % 20) != 0;
      rst_n     = ($urandom % 800) != 0;
      for (int i = 0; i < NCH; i++)
        if ($urandom % 60 == 0) sw[i] = ~sw[i];
      cyc();
    end
    rst_n = 1; ovf_clr = 0; en = 1;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
